// File: rtl/reset_sequencer.sv
// reset_sequencer: sequences core and peripheral-engine reset release with done pulses
module reset_sequencer #(
    parameter int HOLD_CYCLES = 16,
    parameter int PE_DELAY    = 8,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pe_rst,
    output logic core_rst,
    output logic pe_rst_out,
    output logic rst_done,
    output logic pe_done,
    output logic busy
);
    localparam logic [1:0] S_RESET   = 2'd0;
    localparam logic [1:0] S_HOLD    = 2'd1;
    localparam logic [1:0] S_PE_WAIT = 2'd2;
    localparam logic [1:0] S_RUN     = 2'd3;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] PE_LAST   = CNT_W'(PE_DELAY - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             por;

    // por remembers whether the pending PE release finishes a full power-on sequence
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_RESET;
            cnt      <= '0;
            por      <= 1'b1;
            rst_done <= 1'b0;
            pe_done  <= 1'b0;
        end else begin
            rst_done <= 1'b0;
            pe_done  <= 1'b0;
            case (state)
                S_RESET: begin
                    state <= S_HOLD;
                    cnt   <= '0;
                end
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state <= S_PE_WAIT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_PE_WAIT: begin
                    if (pe_rst) begin
                        cnt <= '0;
                    end else if (cnt == PE_LAST) begin
                        state    <= S_RUN;
                        cnt      <= '0;
                        rst_done <= por;
                        pe_done  <= ~por;
                        por      <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (pe_rst) begin
                        state <= S_PE_WAIT;
                        cnt   <= '0;
                        por   <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Moore decode of the registered state
    always_comb begin
        core_rst   = (state == S_RESET) || (state == S_HOLD);
        pe_rst_out = state != S_RUN;
        busy       = state != S_RUN;
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: randomized and directed checks against a release-timer reference model
module tb_reset_sequencer;
    localparam int HOLD = 4;
    localparam int PED  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pe_rst = 1'b0;
    logic core_rst, pe_rst_out, rst_done, pe_done, busy;

    int vectors = 0;
    int miscompares = 0;

    // reference model: counts of consecutive qualifying samples rather than FSM states
    int  low_run = 0;
    int  quiet = 0;
    bit  por_m = 1'b1;
    bit  pe_prev = 1'b1;
    logic [4:0] exp_v = 5'b11001;
    logic [4:0] obs;

    reset_sequencer #(.HOLD_CYCLES(HOLD), .PE_DELAY(PED), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .pe_rst(pe_rst),
        .core_rst(core_rst), .pe_rst_out(pe_rst_out),
        .rst_done(rst_done), .pe_done(pe_done), .busy(busy)
    );

    always #5 clk = ~clk;

    assign obs = {core_rst, pe_rst_out, rst_done, pe_done, busy};

    task automatic step(input bit r, input bit p);
        bit core_was_free, core_now, pe_now, fall;
        rst = r;
        pe_rst = p;
        @(posedge clk);
        if (r) begin
            low_run = 0;
            quiet   = 0;
            por_m   = 1'b1;
            pe_prev = 1'b1;
            exp_v   = 5'b11001;
        end else begin
            core_was_free = low_run > HOLD;
            low_run = (low_run + 1 > HOLD + 1) ? HOLD + 1 : low_run + 1;
            if (core_was_free) quiet = p ? 0 : ((quiet + 1 > PED) ? PED : quiet + 1);
            core_now = low_run <= HOLD;
            pe_now   = core_now || quiet < PED;
            fall     = pe_prev && !pe_now;
            exp_v    = {core_now, pe_now, fall && por_m, fall && !por_m, pe_now};
            if (fall) por_m = 1'b0;
            pe_prev = pe_now;
        end
        #1;
    endtask

    task automatic test_reset();
        int fall_core, fall_pe;
        fall_core = -1;
        fall_pe = -1;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0);
            vectors++;
            if (obs !== exp_v) begin
                $display("FAIL reset_hold cyc %0d got %b want %b", i, obs, exp_v);
                miscompares++;
            end
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0);
            vectors++;
            if (obs !== exp_v) begin
                $display("FAIL power_on T0+%0d got %b want %b", i, obs, exp_v);
                miscompares++;
            end
            if (fall_core < 0 && !core_rst) fall_core = i;
            if (fall_pe < 0 && !pe_rst_out) fall_pe = i;
        end
        vectors++;
        if (fall_core !== HOLD || fall_pe !== HOLD + PED) begin
            $display("FAIL release_latency got core %0d pe %0d want %0d %0d", fall_core, fall_pe, HOLD, HOLD + PED);
            miscompares++;
        end
    endtask

    task automatic test_pe_reset();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, i < 2);
            vectors++;
            if (obs !== exp_v) begin
                $display("FAIL pe_only cyc %0d got %b want %b", i, obs, exp_v);
                miscompares++;
            end
            pulses += pe_done;
        end
        vectors++;
        if (pulses !== 1) begin
            $display("FAIL pe_done_count got %0d want 1", pulses);
            miscompares++;
        end
    endtask

    task automatic test_rst_mid_wait();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(i == 5, 1'b0);
            vectors++;
            if (obs !== exp_v) begin
                $display("FAIL rst_mid_wait cyc %0d got %b want %b", i, obs, exp_v);
                miscompares++;
            end
        end
    endtask

    task automatic test_pe_glitch();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 14; i++) begin
            step(1'b0, i == 5);
            vectors++;
            if (obs !== exp_v) begin
                $display("FAIL pe_glitch cyc %0d got %b want %b", i, obs, exp_v);
                miscompares++;
            end
        end
    endtask

    task automatic test_rst_and_pe();
        step(1'b1, 1'b1);
        vectors++;
        if (obs !== 5'b11001 || obs !== exp_v) begin
            $display("FAIL rst_and_pe got %b want %b", obs, exp_v);
            miscompares++;
        end
    endtask

    task automatic test_pe_in_hold();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, (i < HOLD) ? i[0] : 1'b0);
            vectors++;
            if (obs !== exp_v) begin
                $display("FAIL pe_in_hold cyc %0d got %b want %b", i, obs, exp_v);
                miscompares++;
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0);
            vectors++;
            if (obs !== exp_v || (rst_done && pe_done)) begin
                $display("FAIL random cyc %0d got %b want %b", i, obs, exp_v);
                miscompares++;
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_pe_reset();
        test_rst_mid_wait();
        test_pe_glitch();
        test_pe_reset();
        test_rst_and_pe();
        test_pe_in_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
